// File: rtl/mdio_pkg.sv
// mdio_pkg
//  Shared definitions for the Clause-22 MDIO PHY responder:
//  frame FSM state encoding, opcode values, register addresses and
//  preamble length.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_PRE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_RDATA,
        S_WDATA
    } mdio_state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [4:0] REG_BMCR    = 5'd0;
    localparam logic [4:0] REG_BMSR    = 5'd1;
    localparam logic [4:0] REG_PHYID1  = 5'd2;
    localparam logic [4:0] REG_PHYID2  = 5'd3;
    localparam logic [4:0] REG_ANAR    = 5'd4;
    localparam logic [4:0] REG_ANLPAR  = 5'd5;
    localparam logic [4:0] REG_SCRATCH = 5'd6;

    localparam int         PREAMBLE_LEN = 32;
    localparam logic [15:0] BMCR_RST    = 16'h1000;

endpackage

// File: rtl/mdio_edge_sync.sv
// mdio_edge_sync
//  Brings the asynchronous MDC and MDIO inputs into the system clock
//  domain with two-flop synchronisers and flags the cycle on which a
//  rising MDC edge is seen. The synchronised MDIO value is presented
//  alongside the rise flag so the caller samples both on the same cycle.
// Ports
//  clock         in   system clock
//  reset_n       in   asynchronous active-low reset
//  mdc_i         in   raw MDC
//  mdio_i        in   raw MDIO pad input
//  mdc_rise_o    out  1 for one clock when synchronised MDC goes 0 -> 1
//  mdio_sample_o out  synchronised MDIO, valid on the rise cycle
module mdio_edge_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic mdc_rise_o,
    output logic mdio_sample_o
);

    logic mdc_meta, mdc_sync, mdc_prev;
    logic mdio_meta, mdio_sync;

    // Both inputs go through the same depth so MDIO stays aligned to MDC.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mdc_meta  <= 1'b0;
            mdc_sync  <= 1'b0;
            mdc_prev  <= 1'b0;
            mdio_meta <= 1'b1;
            mdio_sync <= 1'b1;
        end else begin
            mdc_meta  <= mdc_i;
            mdc_sync  <= mdc_meta;
            mdc_prev  <= mdc_sync;
            mdio_meta <= mdio_i;
            mdio_sync <= mdio_meta;
        end
    end

    assign mdc_rise_o    = mdc_sync & ~mdc_prev;
    assign mdio_sample_o = mdio_sync;

endmodule

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder
//  Clause-22 MDIO management responder (PHY side). Decodes read and
//  write frames on MDC/MDIO and serves a small register file:
//  0 BMCR (RW), 1 BMSR (RO), 2/3 PHY ID (RO), 4 ANAR (RW),
//  5 ANLPAR (RO), 6 scratch (RW); other addresses read zero.
//  The system clock must run at least 8x the MDC frequency.
// Configuration
//  MDIO_PREAMBLE_SUPPRESS_EN: when defined, a 0 after at least one
//  preamble 1 starts a frame; otherwise 32 ones are required.
// Ports
//  clock, reset_n      system clock, asynchronous active-low reset
//  mdc_i, mdio_i       MDC and MDIO pad input from the master
//  mdio_o, mdio_oe_o   MDIO drive value and drive enable
//  link_up_i           link status mirrored into BMSR/ANLPAR
//  bmcr_o, anar_o      current BMCR and ANAR contents
//  wr_pulse_o          1-cycle pulse per accepted write
//  wr_addr_o           register address of the last accepted write
//  frame_err_o         1-cycle pulse on bad ST, OP or write TA
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR  = 5'd1,
    parameter logic [15:0] PHY_ID1   = 16'h0022,
    parameter logic [15:0] PHY_ID2   = 16'h1619,
    parameter logic [15:0] BMSR_BASE = 16'h7849,
    parameter logic [15:0] ANAR_RST  = 16'h01E1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        link_up_i,
    output logic [15:0] bmcr_o,
    output logic [15:0] anar_o,
    output logic        wr_pulse_o,
    output logic [4:0]  wr_addr_o,
    output logic        frame_err_o
);

    logic mdc_rise, mdio_bit;

    mdio_edge_sync u_sync (
        .clock         (clock),
        .reset_n       (reset_n),
        .mdc_i         (mdc_i),
        .mdio_i        (mdio_i),
        .mdc_rise_o    (mdc_rise),
        .mdio_sample_o (mdio_bit)
    );

    mdio_state_t state, state_next;
    logic [5:0]  pre_cnt, pre_cnt_next;
    logic [4:0]  bit_cnt, bit_cnt_next;
    logic [1:0]  op_q, op_next;
    logic [4:0]  phyad_q, phyad_next, regad_q, regad_next;
    logic        ta_q, ta_next;
    logic [15:0] shreg, shreg_next;
    logic [15:0] bmcr_q, bmcr_next, anar_q, anar_next, scratch_q, scratch_next;
    logic        mdio_next, oe_next, wr_pulse_next, frame_err_next;
    logic [4:0]  wr_addr_next;
    logic [15:0] rd_data, bmsr;
    logic [4:0]  rd_addr;
    logic [15:0] wdata;
    logic        preamble_ok;

    // The read address is complete on the final REGAD rise, so the
    // incoming bit is folded in to snapshot the register on that cycle.
    assign rd_addr = {regad_q[3:0], mdio_bit};
    assign wdata   = {shreg[14:0], mdio_bit};

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign preamble_ok = (pre_cnt != 6'd0);
`else
    assign preamble_ok = (pre_cnt == 6'(PREAMBLE_LEN));
`endif

    // Register read mux; BMSR link and AN-complete bits track live inputs.
    always_comb begin
        bmsr    = BMSR_BASE;
        bmsr[2] = link_up_i;
        bmsr[5] = link_up_i & bmcr_q[12];
        rd_data = 16'h0000;
        case (rd_addr)
            REG_BMCR:    rd_data = {1'b0, bmcr_q[14:0]};
            REG_BMSR:    rd_data = bmsr;
            REG_PHYID1:  rd_data = PHY_ID1;
            REG_PHYID2:  rd_data = PHY_ID2;
            REG_ANAR:    rd_data = anar_q;
            REG_ANLPAR:  rd_data = link_up_i ? anar_q : 16'h0000;
            REG_SCRATCH: rd_data = scratch_q;
            default:     rd_data = 16'h0000;
        endcase
    end

    // Frame decoder: every field advances only on a detected MDC rise.
    always_comb begin
        state_next     = state;
        pre_cnt_next   = pre_cnt;
        bit_cnt_next   = bit_cnt;
        op_next        = op_q;
        phyad_next     = phyad_q;
        regad_next     = regad_q;
        ta_next        = ta_q;
        shreg_next     = shreg;
        bmcr_next      = bmcr_q;
        anar_next      = anar_q;
        scratch_next   = scratch_q;
        mdio_next      = mdio_o;
        oe_next        = mdio_oe_o;
        wr_pulse_next  = 1'b0;
        wr_addr_next   = wr_addr_o;
        frame_err_next = 1'b0;
        if (mdc_rise) begin
            case (state)
                S_PRE: begin
                    if (mdio_bit) begin
                        if (pre_cnt != 6'(PREAMBLE_LEN))
                            pre_cnt_next = pre_cnt + 6'd1;
                    end else begin
                        // This 0 is the first start bit when the preamble was long enough.
                        pre_cnt_next = 6'd0;
                        if (preamble_ok)
                            state_next = S_ST;
                    end
                end
                S_ST: begin
                    bit_cnt_next = 5'd0;
                    if (mdio_bit) begin
                        state_next = S_OP;
                    end else begin
                        state_next     = S_PRE;
                        frame_err_next = 1'b1;
                    end
                end
                S_OP: begin
                    op_next = {op_q[0], mdio_bit};
                    if (bit_cnt == 5'd0) begin
                        bit_cnt_next = 5'd1;
                    end else begin
                        bit_cnt_next = 5'd0;
                        if (op_next == OP_READ || op_next == OP_WRITE) begin
                            state_next = S_PHYAD;
                        end else begin
                            state_next     = S_PRE;
                            frame_err_next = 1'b1;
                        end
                    end
                end
                S_PHYAD: begin
                    phyad_next   = {phyad_q[3:0], mdio_bit};
                    bit_cnt_next = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd4) begin
                        bit_cnt_next = 5'd0;
                        state_next   = S_REGAD;
                    end
                end
                S_REGAD: begin
                    regad_next   = rd_addr;
                    bit_cnt_next = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd4) begin
                        bit_cnt_next = 5'd0;
                        // Frames for another PHY are dropped without complaint.
                        if (phyad_q != PHY_ADDR) begin
                            state_next = S_PRE;
                        end else begin
                            state_next = S_TA;
                            if (op_q == OP_READ)
                                shreg_next = rd_data;
                        end
                    end
                end
                S_TA: begin
                    if (bit_cnt == 5'd0) begin
                        ta_next      = mdio_bit;
                        bit_cnt_next = 5'd1;
                    end else begin
                        bit_cnt_next = 5'd0;
                        if (op_q == OP_READ) begin
                            oe_next    = 1'b1;
                            mdio_next  = 1'b0;
                            state_next = S_RDATA;
                        end else if ({ta_q, mdio_bit} == 2'b10) begin
                            state_next = S_WDATA;
                        end else begin
                            state_next     = S_PRE;
                            frame_err_next = 1'b1;
                        end
                    end
                end
                S_RDATA: begin
                    // 16 rises present D15..D0; the 17th is where the master samples D0.
                    if (bit_cnt == 5'd16) begin
                        oe_next      = 1'b0;
                        mdio_next    = 1'b1;
                        bit_cnt_next = 5'd0;
                        state_next   = S_PRE;
                    end else begin
                        mdio_next    = shreg[15];
                        shreg_next   = {shreg[14:0], 1'b0};
                        bit_cnt_next = bit_cnt + 5'd1;
                    end
                end
                S_WDATA: begin
                    shreg_next   = wdata;
                    bit_cnt_next = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd15) begin
                        bit_cnt_next  = 5'd0;
                        state_next    = S_PRE;
                        wr_pulse_next = 1'b1;
                        wr_addr_next  = regad_q;
                        case (regad_q)
                            REG_BMCR: begin
                                // Soft reset restores BMCR and ANAR; bit15 never sticks.
                                if (wdata[15]) begin
                                    bmcr_next = BMCR_RST;
                                    anar_next = ANAR_RST;
                                end else begin
                                    bmcr_next = wdata;
                                end
                            end
                            REG_ANAR:    anar_next    = wdata;
                            REG_SCRATCH: scratch_next = wdata;
                            default:     ;
                        endcase
                    end
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_PRE;
            pre_cnt     <= 6'd0;
            bit_cnt     <= 5'd0;
            op_q        <= 2'b00;
            phyad_q     <= 5'd0;
            regad_q     <= 5'd0;
            ta_q        <= 1'b0;
            shreg       <= 16'h0000;
            bmcr_q      <= BMCR_RST;
            anar_q      <= ANAR_RST;
            scratch_q   <= 16'h0000;
            mdio_o      <= 1'b1;
            mdio_oe_o   <= 1'b0;
            wr_pulse_o  <= 1'b0;
            wr_addr_o   <= 5'd0;
            frame_err_o <= 1'b0;
        end else begin
            state       <= state_next;
            pre_cnt     <= pre_cnt_next;
            bit_cnt     <= bit_cnt_next;
            op_q        <= op_next;
            phyad_q     <= phyad_next;
            regad_q     <= regad_next;
            ta_q        <= ta_next;
            shreg       <= shreg_next;
            bmcr_q      <= bmcr_next;
            anar_q      <= anar_next;
            scratch_q   <= scratch_next;
            mdio_o      <= mdio_next;
            mdio_oe_o   <= oe_next;
            wr_pulse_o  <= wr_pulse_next;
            wr_addr_o   <= wr_addr_next;
            frame_err_o <= frame_err_next;
        end
    end

    assign bmcr_o = bmcr_q;
    assign anar_o = anar_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder
//  Drives MDIO frames as a master would (data changed while MDC is low),
//  keeps a register-level model of the PHY, and queues expected read
//  data and write addresses. Independent monitors compare serial read
//  data, write pulses and frame-error pulses against those queues.
module tb_mdio_phy_responder;

    localparam time        CLK_HALF = 5ns;
    localparam time        MDC_HALF = 60ns;
    localparam logic [4:0] MY_PHY   = 5'd1;

    logic        clock, reset_n, mdc, mdio_in, link_up;
    logic        mdio_o, mdio_oe_o, wr_pulse_o, frame_err_o;
    logic [15:0] bmcr_o, anar_o;
    logic [4:0]  wr_addr_o;

    mdio_phy_responder dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mdc_i       (mdc),
        .mdio_i      (mdio_in),
        .mdio_o      (mdio_o),
        .mdio_oe_o   (mdio_oe_o),
        .link_up_i   (link_up),
        .bmcr_o      (bmcr_o),
        .anar_o      (anar_o),
        .wr_pulse_o  (wr_pulse_o),
        .wr_addr_o   (wr_addr_o),
        .frame_err_o (frame_err_o)
    );

    initial clock = 1'b0;
    always #CLK_HALF clock = ~clock;

    int checks = 0;
    int passes = 0;
    int err_seen = 0;
    int exp_err = 0;
    logic [15:0] rd_q[$];
    logic [4:0]  wr_q[$];

    // Behavioural register model
    logic [15:0] m_bmcr, m_anar, m_scratch;

    task automatic model_reset();
        m_bmcr    = 16'h1000;
        m_anar    = 16'h01E1;
        m_scratch = 16'h0000;
    endtask

    function automatic logic [15:0] model_read(input logic [4:0] a);
        logic [15:0] v;
        case (a)
            5'd0: v = m_bmcr & 16'h7FFF;
            5'd1: begin
                v = 16'h7849;
                v[2] = link_up;
                v[5] = link_up & m_bmcr[12];
            end
            5'd2: v = 16'h0022;
            5'd3: v = 16'h1619;
            5'd4: v = m_anar;
            5'd5: v = link_up ? m_anar : 16'h0000;
            5'd6: v = m_scratch;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [15:0] d);
        if (a == 5'd0) begin
            if (d[15]) begin
                m_bmcr = 16'h1000;
                m_anar = 16'h01E1;
            end else begin
                m_bmcr = d;
            end
        end else if (a == 5'd4) begin
            m_anar = d;
        end else if (a == 5'd6) begin
            m_scratch = d;
        end
    endtask

    function automatic bit preamble_ok(input int n);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        return n >= 1;
`else
        return n >= 32;
`endif
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_regs();
        check_output("bmcr_o", 32'(bmcr_o), 32'(m_bmcr));
        check_output("anar_o", 32'(anar_o), 32'(m_anar));
        check_output("frame_err_count", 32'(err_seen), 32'(exp_err));
    endtask

    // Master-side bit driver: change MDIO while MDC is low, then raise MDC.
    task automatic mdc_bit(input logic b);
        mdio_in = b;
        #MDC_HALF mdc = 1'b1;
        #MDC_HALF mdc = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) mdc_bit(v[i]);
    endtask

    // Full frame; the tail supplies the rise that samples D0 plus idle.
    task automatic send_frame(input int pre_len, input logic [1:0] st, input logic [1:0] op,
                              input logic [4:0] phy, input logic [4:0] regad,
                              input logic [1:0] ta, input logic [15:0] data, input bit flip_link);
        for (int i = 0; i < pre_len; i++) mdc_bit(1'b1);
        send_bits(64'({st, op, phy, regad}), 14);
        if (flip_link) link_up = ~link_up;
        send_bits(64'(ta), 2);
        send_bits(64'(data), 16);
        send_bits(64'(3'b111), 3);
    endtask

    task automatic apply_read(input logic [4:0] phy, input logic [4:0] regad, input bit flip_link);
        if (phy == MY_PHY) rd_q.push_back(model_read(regad));
        send_frame(32, 2'b01, 2'b10, phy, regad, 2'b11, 16'hFFFF, flip_link);
        check_regs();
    endtask

    task automatic apply_write(input int pre_len, input logic [4:0] phy, input logic [4:0] regad,
                               input logic [1:0] ta, input logic [15:0] data);
        if (preamble_ok(pre_len) && phy == MY_PHY) begin
            if (ta == 2'b10) begin
                model_write(regad, data);
                wr_q.push_back(regad);
            end else begin
                exp_err++;
            end
        end
        send_frame(pre_len, 2'b01, 2'b01, phy, regad, ta, data, 1'b0);
        check_regs();
    endtask

    task automatic apply_bad(input logic [1:0] st, input logic [1:0] op);
        exp_err++;
        send_frame(32, st, op, MY_PHY, 5'($urandom_range(0, 7)), 2'b10, 16'($urandom), 1'b0);
        check_regs();
    endtask

    // Read monitor: collects every bit presented while MDIO is driven.
    initial begin
        int          nbits;
        logic [16:0] sh;
        bit          active;
        logic [15:0] exp;
        nbits  = 0;
        sh     = '0;
        active = 0;
        forever begin
            @(posedge mdc or negedge reset_n);
            if (!reset_n) begin
                active = 0;
                nbits  = 0;
            end else if (mdio_oe_o) begin
                active = 1;
                sh     = {sh[15:0], mdio_o};
                nbits++;
            end else if (active) begin
                active = 0;
                check_output("rd_len", 32'(nbits), 32'd17);
                check_output("rd_ta_bit", 32'(sh[16]), 32'd0);
                if (rd_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL rd_unexpected: got 0x%0h, expected no read", sh[15:0]);
                end else begin
                    exp = rd_q.pop_front();
                    check_output("rd_data", 32'(sh[15:0]), 32'(exp));
                end
                nbits = 0;
            end
        end
    end

    // Write-pulse and frame-error monitors.
    initial begin
        logic [4:0] a;
        forever begin
            @(negedge clock);
            if (frame_err_o) err_seen++;
            if (wr_pulse_o) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL wr_unexpected: got addr %0d, expected no write", wr_addr_o);
                end else begin
                    a = wr_q.pop_front();
                    check_output("wr_addr", 32'(wr_addr_o), 32'(a));
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [1:0] ta;
        mdc     = 1'b0;
        mdio_in = 1'b1;
        link_up = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #25ns;
        check_output("rst_mdio_o", 32'(mdio_o), 32'd1);
        check_output("rst_oe", 32'(mdio_oe_o), 32'd0);
        check_output("rst_bmcr", 32'(bmcr_o), 32'h1000);
        check_output("rst_anar", 32'(anar_o), 32'h01E1);
        check_output("rst_wr_pulse", 32'(wr_pulse_o), 32'd0);
        check_output("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        check_output("rst_frame_err", 32'(frame_err_o), 32'd0);
        reset_n = 1'b1;
        #100ns;

        $display("[TB] directed frames");
        apply_read(MY_PHY, 5'd2, 1'b0);
        apply_write(32, MY_PHY, 5'd4, 2'b10, 16'h05E1);
        apply_read(MY_PHY, 5'd4, 1'b0);
        apply_read(5'd2, 5'd2, 1'b0);
        apply_read(MY_PHY, 5'd3, 1'b0);
        apply_write(32, MY_PHY, 5'd0, 2'b10, 16'h8000);
        apply_read(MY_PHY, 5'd0, 1'b0);
        apply_write(32, MY_PHY, 5'd6, 2'b11, 16'h1234);
        apply_bad(2'b00, 2'b10);
        apply_bad(2'b01, 2'b11);
        apply_write(32, MY_PHY, 5'd2, 2'b10, 16'hABCD);
        apply_write(20, MY_PHY, 5'd6, 2'b10, 16'h5A5A);
        apply_read(MY_PHY, 5'd6, 1'b0);
        link_up = 1'b1;
        apply_read(MY_PHY, 5'd1, 1'b1);
        apply_read(MY_PHY, 5'd5, 1'b0);

        $display("[TB] randomized frames");
        for (int n = 0; n < 24; n++) begin
            link_up = 1'($urandom);
            case ($urandom_range(0, 6))
                0, 1: apply_read(MY_PHY, 5'($urandom_range(0, 8)), 1'($urandom));
                2, 3: apply_write(32, MY_PHY, 5'($urandom_range(0, 8)), 2'b10, 16'($urandom));
                4: begin
                    if ($urandom_range(0, 1) == 0)
                        apply_read(5'($urandom_range(2, 31)), 5'($urandom_range(0, 6)), 1'b0);
                    else
                        apply_write(32, 5'($urandom_range(2, 31)), 5'($urandom_range(0, 6)), 2'b10, 16'($urandom));
                end
                5: apply_bad(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01,
                             ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11);
                default: begin
                    ta = 2'($urandom_range(0, 2));
                    if (ta == 2'b10) ta = 2'b11;
                    apply_write(32, MY_PHY, 5'($urandom_range(0, 6)), ta, 16'($urandom));
                end
            endcase
        end

        $display("[TB] reset during read data");
        apply_write(32, MY_PHY, 5'd4, 2'b10, 16'h0021);
        for (int i = 0; i < 32; i++) mdc_bit(1'b1);
        send_bits(64'({2'b01, 2'b10, MY_PHY, 5'd2}), 14);
        send_bits(64'(2'b11), 2);
        for (int i = 0; i < 9; i++) mdc_bit(1'b1);
        #20ns reset_n = 1'b0;
        #1ns;
        check_output("mid_reset_oe", 32'(mdio_oe_o), 32'd0);
        check_output("mid_reset_anar", 32'(anar_o), 32'h01E1);
        model_reset();
        #40ns reset_n = 1'b1;
        #100ns;
        link_up = 1'b1;
        apply_read(MY_PHY, 5'd1, 1'b0);

        #500ns;
        check_output("rd_pending", 32'(rd_q.size()), 32'd0);
        check_output("wr_pending", 32'(wr_q.size()), 32'd0);
        check_output("frame_err_final", 32'(err_seen), 32'(exp_err));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
